// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/coordinate generator with look-ahead fetch stream
module vga_timing_gen #(
  parameter int   CW   = 10,
  parameter int   HD   = 640,
  parameter int   HF   = 16,
  parameter int   HS   = 96,
  parameter int   HB   = 48,
  parameter int   VD   = 480,
  parameter int   VF   = 10,
  parameter int   VS   = 2,
  parameter int   VB   = 33,
  parameter logic HPOL = 1'b0,
  parameter logic VPOL = 1'b0,
  parameter int   LEAD = 2
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          ce,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          valid,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          line_start,
  output logic          frame_start,
  output logic          fetch_valid,
  output logic [CW-1:0] fetch_h,
  output logic [CW-1:0] fetch_v
);
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam logic [CW-1:0] HM  = CW'(HT - 1);
  localparam logic [CW-1:0] VM  = CW'(VT - 1);
  localparam logic [CW-1:0] HA  = CW'(HD);
  localparam logic [CW-1:0] VA  = CW'(VD);
  localparam logic [CW-1:0] HS0 = CW'(HD + HF);
  localparam logic [CW-1:0] HS1 = CW'(HD + HF + HS);
  localparam logic [CW-1:0] VS0 = CW'(VD + VF);
  localparam logic [CW-1:0] VS1 = CW'(VD + VF + VS);
  localparam logic [CW-1:0] LH0 = CW'(LEAD % HT);
  localparam logic [CW-1:0] LV0 = CW'((LEAD / HT) % VT);
  logic [CW-1:0] hc, vc, lh, lv;
  logic act, fact, fresh;
  assign act  = hc < HA && vc < VA;
  assign fact = lh < HA && lv < VA;
  // Main and lead counters: both advance per pixel tick, lead stays LEAD ticks ahead
  always_ff @(posedge pclk) begin
    if (!reset || !en) begin
      hc <= '0;
      vc <= '0;
      lh <= LH0;
      lv <= LV0;
    end else if (ce) begin
      hc <= hc == HM ? '0 : hc + 1'b1;
      vc <= hc == HM ? (vc == VM ? '0 : vc + 1'b1) : vc;
      lh <= lh == HM ? '0 : lh + 1'b1;
      lv <= lh == HM ? (lv == VM ? '0 : lv + 1'b1) : lv;
    end
  end
  // Registered decode; fresh marks a position not yet shown so strobes last one pclk
  always_ff @(posedge pclk) begin
    if (!reset || !en) begin
      hsync       <= ~HPOL;
      vsync       <= ~VPOL;
      valid       <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_h     <= '0;
      fetch_v     <= '0;
      fresh       <= 1'b1;
    end else begin
      fresh       <= ce;
      hsync       <= (hc >= HS0 && hc < HS1) ? HPOL : ~HPOL;
      vsync       <= (vc >= VS0 && vc < VS1) ? VPOL : ~VPOL;
      valid       <= act;
      h_cnt       <= act ? hc : '0;
      v_cnt       <= act ? vc : '0;
      line_start  <= fresh && hc == '0;
      frame_start <= fresh && hc == '0 && vc == '0;
      fetch_valid <= fact;
      fetch_h     <= fact ? lh : '0;
      fetch_v     <= fact ? lv : '0;
    end
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor to the fixed 640x480 VGA controller. Generates horizontal and vertical sync, active-video flag and pixel coordinates for any mode, with programmable sync polarity, a pixel clock-enable for running off a faster system clock, a run enable, and line/frame start strobes. It also provides a look-ahead fetch coordinate stream, LEAD pixel ticks early, so frame-buffer and sprite ROM reads can cover their latency. It sits between the pixel clock domain and the renderer/frame-buffer logic.

## Interface
- CW, 10: width of counters and coordinate outputs; HT-1 and VT-1 must fit in CW bits
- HD, 640: horizontal active pixels
- HF, 16: horizontal front porch
- HS, 96: horizontal sync width
- HB, 48: horizontal back porch
- VD, 480: vertical active lines
- VF, 10: vertical front porch
- VS, 2: vertical sync width
- VB, 33: vertical back porch
- HPOL, 0: hsync active level (0 = active-low)
- VPOL, 0: vsync active level (0 = active-low)
- LEAD, 2: fetch look-ahead in pixel ticks, 0 <= LEAD < HT
- Derived: HT = HD+HF+HS+HB, VT = VD+VF+VS+VB
- pclk  in  1  clock
- reset  in  1  synchronous, active-low reset
- ce  in  1  pixel tick enable; counters advance only on pclk edges with ce=1
- en  in  1  run enable
- hsync, vsync  out  1  sync outputs, polarity per HPOL/VPOL
- valid  out  1  position in active area
- h_cnt, v_cnt  out  CW  active coordinates; 0 when outside the active area
- line_start  out  1  one-pclk strobe when the outputs first show hc=0 of a line
- frame_start  out  1  one-pclk strobe when the outputs first show (0,0)
- fetch_valid  out  1  look-ahead position is in the active area
- fetch_h, fetch_v  out  CW  look-ahead coordinates; 0 when fetch_valid=0

## Operation
- Main counter (hc,vc): on pclk with ce=1 and en=1, hc increments; at HT-1, hc wraps to 0 and vc increments; at (HT-1,VT-1), both wrap to (0,0).
- Lead counter (lh,lv) advances under the same conditions and stays exactly LEAD ticks ahead of (hc,vc), modulo one full frame (HT*VT ticks), including line and frame wrap.
- en=0: main counter forced to (0,0), lead counter to the position LEAD ticks after (0,0). All outputs take their reset values. The first tick after en rises leaves (0,0).
- Decode, computed from the counter and registered into the outputs:
  - valid = hc<HD && vc<VD.
  - hsync active for HD+HF <= hc < HD+HF+HS.
  - vsync active for VD+VF <= vc < VD+VF+VS, changing only with vc.
  - h_cnt/v_cnt = hc/vc when valid, else 0.
  - fetch_* decode identically from (lh,lv).
- line_start = 1 for exactly one pclk when the registered hc becomes 0 (tick, or en rising). frame_start is the same condition with vc=0 as well. Strobes never exceed one pclk when ce is held low.
- Reset values: hsync=~HPOL, vsync=~VPOL, valid=0, h_cnt=v_cnt=0, line_start=frame_start=0, fetch_valid=0, fetch_h=fetch_v=0. Counters are set to (0,0) and lead (0,0)+LEAD.
- Reset asserted mid-frame: all of the above take effect on the next pclk edge. Reset dominates en and ce.

## Timing
- All outputs are registered. Outputs reflect the counter state one pclk earlier; total latency from tick to output is 1 pclk.
- With ce=1 continuously, the line period is HT pclk and the frame period is HT*VT pclk.
- With ce at 1/N duty, all periods scale by N and the strobes stay 1 pclk wide.
- Output set for a position (h_cnt, v_cnt, valid, syncs) changes atomically in a single pclk.
- fetch_* equals the position the main outputs will show LEAD ticks later. With LEAD=0, fetch_* equals h_cnt/v_cnt/valid.

## Test plan
- Defaults, ce=1, en=1 after reset:
  - hsync goes low 657 pclk after reset release and stays low for 96 pclk.
  - Line period is 800 pclk.
  - vsync is low for 1600 pclk per 420000-pclk frame.
  - valid is high for 640 pclk per line on lines 0-479 only.
- ce toggling 1,0: hsync low for 192 pclk and line period 1600 pclk. line_start and frame_start are each 1 pclk wide, with one frame_start per 840000 pclk.
- Small mode HD=4 HF=1 HS=1 HB=1 VD=2 VF=1 VS=1 VB=1 HPOL=1 VPOL=1, ce=1:
  - h_cnt sequence is 0,1,2,3,0,0,0.
  - hsync is high only at hc=5.
  - vsync is high for the 7 pclk of line 3.
  - Frame is 35 pclk.
- LEAD=2, defaults:
  - When h_cnt=5, fetch_h=7.
  - When the outputs show (798,524), fetch shows (0,0) with fetch_valid=1, while valid=0.
  - fetch_valid falls 2 pclk before valid falls on every line.
- Reset pulsed low for 1 pclk at (300,200): the next pclk shows reset values. Afterwards the sequence restarts from (0,0) with frame_start=1.
- en dropped low at (100,50) for 10 pclk:
  - Outputs show reset values while en is low.
  - On en rise, frame_start and line_start pulse together.
  - Frame timing restarts from (0,0).
